motion_cmd_sequencer: RTL and testbench

MOTION_CMD_SEQUENCER -- requirements
Module: motion_cmd_sequencer

---
 rtl/motion_cmd_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_motion_cmd_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_cmd_sequencer.sv
// Motion command sequencer: accepts a DC-speed + stepper-move command and ramps up, steps, then ramps down.
// Define MOTION_RAMP_EN for RAMP_DIV-paced speed ramps; otherwise speed jumps to target/zero in one cycle.
module motion_cmd_sequencer #(
  parameter int unsigned RAMP_DIV = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_speed,
  input  logic        cmd_dir_dc,
  input  logic [15:0] cmd_steps,
  input  logic        cmd_step_dir,
  input  logic [15:0] cmd_step_period,
  input  logic        abort,
  output logic [7:0]  speed_dc,
  output logic        dir_dc,
  output logic [1:0]  dir_stepper,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ACCEL, STEP, DECEL} state_e;

  state_e      state_q, state_d;
  logic [7:0]  speed_q, speed_d;
  logic [7:0]  target_q, target_d;
  logic        dir_dc_q, dir_dc_d;
  logic [1:0]  step_code_q, step_code_d;
  logic [15:0] steps_left_q, steps_left_d;
  logic [15:0] period_q, period_d;
  logic [15:0] period_cnt_q, period_cnt_d;
  logic [1:0]  dir_stepper_q, dir_stepper_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cmd_ready_q, cmd_ready_d;

`ifdef MOTION_RAMP_EN
  localparam logic [15:0] RAMP_LAST = 16'(RAMP_DIV - 1);
  logic [15:0] ramp_cnt_q, ramp_cnt_d;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case can infer a latch.
    state_d       = state_q;
    speed_d       = speed_q;
    target_d      = target_q;
    dir_dc_d      = dir_dc_q;
    step_code_d   = step_code_q;
    steps_left_d  = steps_left_q;
    period_d      = period_q;
    period_cnt_d  = period_cnt_q;
    dir_stepper_d = 2'b00;
    done_d        = 1'b0;
`ifdef MOTION_RAMP_EN
    ramp_cnt_d    = ramp_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Acceptance wins over abort: abort has no meaning before a command exists.
        if (cmd_valid && cmd_ready_q) begin
          state_d      = ACCEL;
          target_d     = cmd_speed;
          dir_dc_d     = cmd_dir_dc;
          step_code_d  = cmd_step_dir ? 2'b10 : 2'b01;
          steps_left_d = cmd_steps;
          period_d     = (cmd_step_period == 16'd0) ? 16'd1 : cmd_step_period;
          period_cnt_d = 16'd0;
`ifdef MOTION_RAMP_EN
          ramp_cnt_d   = 16'd0;
`endif
        end
      end

      ACCEL: begin
        if (abort) begin
          state_d = DECEL;
`ifdef MOTION_RAMP_EN
          ramp_cnt_d = 16'd0;
`endif
        end else begin
`ifdef MOTION_RAMP_EN
          if (speed_q == target_q) begin
            state_d      = STEP;
            period_cnt_d = 16'd0;
          end else if (ramp_cnt_q == RAMP_LAST) begin
            speed_d    = speed_q + 8'd1;
            ramp_cnt_d = 16'd0;
          end else begin
            ramp_cnt_d = ramp_cnt_q + 16'd1;
          end
`else
          speed_d      = target_q;
          state_d      = STEP;
          period_cnt_d = 16'd0;
`endif
        end
      end

      STEP: begin
        if (abort || steps_left_q == 16'd0) begin
          state_d = DECEL;
`ifdef MOTION_RAMP_EN
          ramp_cnt_d = 16'd0;
`endif
        end else if (period_cnt_q == period_q - 16'd1) begin
          dir_stepper_d = step_code_q;
          steps_left_d  = steps_left_q - 16'd1;
          period_cnt_d  = 16'd0;
        end else begin
          period_cnt_d = period_cnt_q + 16'd1;
        end
      end

      DECEL: begin
        if (speed_q == 8'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
`ifdef MOTION_RAMP_EN
          if (ramp_cnt_q == RAMP_LAST) begin
            speed_d    = speed_q - 8'd1;
            ramp_cnt_d = 16'd0;
          end else begin
            ramp_cnt_d = ramp_cnt_q + 16'd1;
          end
`else
          speed_d = 8'd0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    // Status flags are registered copies of the next state so they line up with it.
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  // NOTE: asynchronous reset drops speed to 0 at once and forgets the latched command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      speed_q       <= 8'd0;
      target_q      <= 8'd0;
      dir_dc_q      <= 1'b0;
      step_code_q   <= 2'b00;
      steps_left_q  <= 16'd0;
      period_q      <= 16'd0;
      period_cnt_q  <= 16'd0;
      dir_stepper_q <= 2'b00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cmd_ready_q   <= 1'b0;
`ifdef MOTION_RAMP_EN
      ramp_cnt_q    <= 16'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q       <= state_d;
      speed_q       <= speed_d;
      target_q      <= target_d;
      dir_dc_q      <= dir_dc_d;
      step_code_q   <= step_code_d;
      steps_left_q  <= steps_left_d;
      period_q      <= period_d;
      period_cnt_q  <= period_cnt_d;
      dir_stepper_q <= dir_stepper_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cmd_ready_q   <= cmd_ready_d;
`ifdef MOTION_RAMP_EN
      ramp_cnt_q    <= ramp_cnt_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign speed_dc    = speed_q;
  assign dir_dc      = dir_dc_q;
  assign dir_stepper = dir_stepper_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
// Self-checking bench for motion_cmd_sequencer (RAMP_DIV=4); expectations come from a closed-form
// timeline of each command, so it works with or without MOTION_RAMP_EN defined.
module tb_motion_cmd_sequencer;

  localparam int D = 4;
`ifdef MOTION_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_speed;
  logic        cmd_dir_dc;
  logic [15:0] cmd_steps;
  logic        cmd_step_dir;
  logic [15:0] cmd_step_period;
  logic        abort;
  logic [7:0]  speed_dc;
  logic        dir_dc;
  logic [1:0]  dir_stepper;
  logic        busy, done;

  motion_cmd_sequencer #(.RAMP_DIV(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_speed(cmd_speed), .cmd_dir_dc(cmd_dir_dc), .cmd_steps(cmd_steps),
    .cmd_step_dir(cmd_step_dir), .cmd_step_period(cmd_step_period),
    .abort(abort),
    .speed_dc(speed_dc), .dir_dc(dir_dc), .dir_stepper(dir_stepper),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Timeline of one command, cycle 0 = first cycle after acceptance.
  int m_t, m_n, m_p, m_la, m_de, m_s, m_idle;
  bit m_dir;
  logic [1:0] m_code;
  int last_strobes, last_busy;

  function automatic int accel_speed(int c);
    return RAMP ? c / D : 0;
  endfunction

  function automatic int accel_len(int t);
    return RAMP ? t * D + 1 : 1;
  endfunction

  task automatic plan(input int t, input int n, input int p, input bit sdir, input int cab);
    int nat;
    m_t    = t;
    m_n    = n;
    m_p    = (p == 0) ? 1 : p;
    m_code = sdir ? 2'b10 : 2'b01;
    m_la   = accel_len(t);
    nat    = m_la + n * m_p + 1;
    if (cab >= 0 && cab < nat) begin
      m_de = cab + 1;
      m_s  = (cab < m_la) ? accel_speed(cab) : t;
    end else begin
      m_de = nat;
      m_s  = t;
    end
    m_idle = m_de + (RAMP ? m_s * D + 1 : ((m_s == 0) ? 1 : 2));
  endtask

  function automatic int exp_speed(int c);
    if (c < m_de)   return (c < m_la) ? accel_speed(c) : m_t;
    if (c < m_idle) return RAMP ? m_s - (c - m_de) / D : ((c == m_de) ? m_s : 0);
    return 0;
  endfunction

  function automatic logic [1:0] exp_strobe(int c);
    if (c > m_la && c < m_de && (c - m_la) % m_p == 0 && (c - m_la) / m_p <= m_n) return m_code;
    return 2'b00;
  endfunction

  function automatic int exp_strobe_count();
    int k = 0;
    for (int m = 1; m <= m_n; m++) if (m_la + m * m_p < m_de) k++;
    return k;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the IDLE-entry cycle
  // (or of cycle stop_at). hold keeps cmd_valid high and flips cmd_dir_dc for a follow-on command.
  task automatic run_cmd(input string tag, input int t, input bit ddir, input int n, input bit sdir,
                         input int p, input int cab, input bit abort_acc, input bit hold,
                         input int stop_at);
    int strobes = 0;
    int dones   = 0;
    int busys   = 0;
    plan(t, n, p, sdir, cab);
    m_dir           = ddir;
    cmd_speed       = t[7:0];
    cmd_dir_dc      = ddir;
    cmd_steps       = n[15:0];
    cmd_step_dir    = sdir;
    cmd_step_period = p[15:0];
    cmd_valid       = 1'b1;
    abort           = abort_acc;
    check($sformatf("%s.ready_at_accept", tag), 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    abort = 1'b0;
    if (hold) cmd_dir_dc = ~ddir;
    else      cmd_valid  = 1'b0;
    for (int c = 0; c <= m_idle; c++) begin
      @(negedge clk);
      check($sformatf("%s.speed@%0d", tag, c),  32'(speed_dc),    32'(exp_speed(c)));
      check($sformatf("%s.strobe@%0d", tag, c), 32'(dir_stepper), 32'(exp_strobe(c)));
      check($sformatf("%s.busy@%0d", tag, c),   32'(busy),        32'(c < m_idle));
      check($sformatf("%s.done@%0d", tag, c),   32'(done),        32'(c == m_idle));
      check($sformatf("%s.ready@%0d", tag, c),  32'(cmd_ready),   32'(c == m_idle));
      check($sformatf("%s.dir_dc@%0d", tag, c), 32'(dir_dc),      32'(m_dir));
      if (dir_stepper != 2'b00) strobes++;
      if (done) dones++;
      if (busy) busys++;
      abort = (c == cab);
      if (c == stop_at) return;
    end
    abort = 1'b0;
    last_strobes = strobes;
    last_busy    = busys;
    check($sformatf("%s.strobe_count", tag), 32'(strobes), 32'(exp_strobe_count()));
    check($sformatf("%s.done_count", tag),   32'(dones),   32'd1);
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check($sformatf("%s.quiet_busy", tag),   32'(busy),        32'd0);
    check($sformatf("%s.quiet_done", tag),   32'(done),        32'd0);
    check($sformatf("%s.quiet_speed", tag),  32'(speed_dc),    32'd0);
    check($sformatf("%s.quiet_strobe", tag), 32'(dir_stepper), 32'd0);
    check($sformatf("%s.quiet_ready", tag),  32'(cmd_ready),   32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, n, p, cab;
    bit dd, sd;
    rst = 1'b1; cmd_valid = 1'b0; cmd_speed = '0; cmd_dir_dc = 1'b0; cmd_steps = '0;
    cmd_step_dir = 1'b0; cmd_step_period = '0; abort = 1'b0;

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    check("rst.speed",  32'(speed_dc),    32'd0);
    check("rst.dir_dc", 32'(dir_dc),      32'd0);
    check("rst.strobe", 32'(dir_stepper), 32'd0);
    check("rst.busy",   32'(busy),        32'd0);
    check("rst.done",   32'(done),        32'd0);
    check("rst.ready",  32'(cmd_ready),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.ready", 32'(cmd_ready), 32'd1);
    check("post_rst.done",  32'(done),      32'd0);

    // Basic ramp, two cw strobes 5 apart.
    run_cmd("r031", 3, 1'b0, 2, 1'b0, 5, -1, 1'b0, 1'b0, -1);
    check_quiet("r031");

    // Zero everything: short trip through all states.
    run_cmd("r032", 0, 1'b1, 0, 1'b1, 0, -1, 1'b0, 1'b0, -1);
    check("r032.busy_le4", 32'(last_busy <= 4), 32'd1);
    check_quiet("r032");

    // Full speed, period 1, abort after the tenth strobe.
    run_cmd("r033", 255, 1'b0, 100, 1'b1, 1, accel_len(255) + 10, 1'b0, 1'b0, -1);
    check("r033.ten_strobes", 32'(last_strobes), 32'd10);
    check_quiet("r033");

    // cmd_valid held across two back-to-back commands with opposite DC direction.
    run_cmd("r034a", 4, 1'b0, 1, 1'b0, 2, -1, 1'b0, 1'b1, -1);
    run_cmd("r034b", 4, 1'b1, 1, 1'b0, 2, -1, 1'b0, 1'b0, -1);
    check_quiet("r034");

    // Large target, single step.
    run_cmd("r035", 200, 1'b1, 1, 1'b0, 2, -1, 1'b0, 1'b0, -1);
    check_quiet("r035");

    // Abort together with acceptance in IDLE still accepts the command.
    run_cmd("acc_abort", 5, 1'b1, 2, 1'b1, 3, -1, 1'b1, 1'b0, -1);
    check_quiet("acc_abort");

    // Abort early in the command.
    run_cmd("abort_early", 6, 1'b0, 3, 1'b0, 2, 3, 1'b0, 1'b0, -1);
    check_quiet("abort_early");

    // Randomized commands, some aborted at a random point.
    for (int i = 0; i < 8; i++) begin
      t  = int'($urandom_range(0, 30));
      n  = int'($urandom_range(0, 4));
      p  = int'($urandom_range(0, 5));
      dd = 1'($urandom_range(0, 1));
      sd = 1'($urandom_range(0, 1));
      plan(t, n, p, sd, -1);
      cab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, m_de - 1)) : -1;
      run_cmd($sformatf("rnd%0d", i), t, dd, n, sd, p, cab, 1'b0, 1'b0, -1);
      check_quiet($sformatf("rnd%0d", i));
    end

    // Reset in the middle of STEP at speed 20.
    run_cmd("r030", 20, 1'b1, 50, 1'b0, 7, -1, 1'b0, 1'b0, accel_len(20) + 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("r030.speed",  32'(speed_dc),    32'd0);
    check("r030.strobe", 32'(dir_stepper), 32'd0);
    check("r030.busy",   32'(busy),        32'd0);
    check("r030.done",   32'(done),        32'd0);
    check("r030.dir_dc", 32'(dir_dc),      32'd0);
    check("r030.ready",  32'(cmd_ready),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("r030.rel_done",  32'(done),      32'd0);
    check("r030.rel_ready", 32'(cmd_ready), 32'd1);
    check("r030.rel_busy",  32'(busy),      32'd0);

    // The discarded command must not resurface; a fresh one runs normally.
    run_cmd("post_r030", 2, 1'b0, 1, 1'b1, 1, -1, 1'b0, 1'b0, -1);
    check_quiet("post_r030");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
